// File: rtl/riscv_rvfi_pkg.sv
// Shared types and helpers for the RVFI retirement monitor.
//   err_code_e  : failure codes reported on err_code, lower value = higher priority
//   mon_state_e : monitor FSM states
//   mask_legal  : byte-mask legality plus address alignment for that mask width
package riscv_rvfi_pkg;

    typedef enum logic [3:0] {
        ERR_NONE    = 4'd0,
        ERR_ORDER   = 4'd1,
        ERR_PC      = 4'd2,
        ERR_X0      = 4'd3,
        ERR_RS1     = 4'd4,
        ERR_RS2     = 4'd5,
        ERR_MASK    = 4'd6,
        ERR_HALT    = 4'd7,
        ERR_TIMEOUT = 4'd8
    } err_code_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAIL   = 2'd2
    } mon_state_e;

    // Byte, aligned halfword or aligned word accesses only; an empty mask is
    // "no access" and always legal.
    function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] addr_lsb);
        case (mask)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            4'b0011, 4'b1100:                            return ~addr_lsb[0];
            4'b1111:                                     return addr_lsb == 2'b00;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rvfi_monitor_if.sv
// RVFI retirement bundle. The hart drives it through the master modport,
// the monitor observes it through the slave modport.
interface rvfi_monitor_if #(
    parameter int XLEN = 32
);
    logic            rvfi_valid;
    logic [63:0]     rvfi_order;
    logic [31:0]     rvfi_insn;
    logic            rvfi_trap;
    logic            rvfi_halt;
    logic            rvfi_intr;
    logic [4:0]      rvfi_rs1_addr;
    logic [4:0]      rvfi_rs2_addr;
    logic [4:0]      rvfi_rd_addr;
    logic [XLEN-1:0] rvfi_rs1_rdata;
    logic [XLEN-1:0] rvfi_rs2_rdata;
    logic [XLEN-1:0] rvfi_rd_wdata;
    logic [XLEN-1:0] rvfi_pc_rdata;
    logic [XLEN-1:0] rvfi_pc_wdata;
    logic [XLEN-1:0] rvfi_mem_addr;
    logic [3:0]      rvfi_mem_rmask;
    logic [3:0]      rvfi_mem_wmask;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
               rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr,
               rvfi_mem_rmask, rvfi_mem_wmask
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
               rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr,
               rvfi_mem_rmask, rvfi_mem_wmask
    );
endinterface

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of the architectural integer registers built from retired rd
// writes. Two combinational read ports, one write port.
//   clk, rst           : clock, synchronous active-high reset (valid bits only)
//   we, waddr, wdata   : write port
//   raddr_a/b          : read addresses
//   rdata_a/b          : stored values
//   rvalid_a/b         : entry has been written since reset (x0 never valid)
module rvfi_shadow_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    output logic [XLEN-1:0] rdata_a,
    output logic            rvalid_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_b,
    output logic            rvalid_b
);
    logic [XLEN-1:0] regs_q [32];
    logic [31:0]     vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (we && waddr != 5'd0) begin
            vld_q[waddr] <= 1'b1;
        end
    end

    // Contents need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rvalid_a = vld_q[raddr_a] && (raddr_a != 5'd0);
    assign rdata_b  = regs_q[raddr_b];
    assign rvalid_b = vld_q[raddr_b] && (raddr_b != 5'd0);
endmodule

// File: rtl/rvfi_monitor.sv
// RVFI retirement monitor: checks order sequence, PC chaining, the x0 rule,
// rs1/rs2 coherence with a shadow register file, memory mask legality,
// halt behaviour and liveness. The first failure is latched and sticky.
//   clk, rst   : clock, synchronous active-high reset
//   rvfi       : retirement bundle (slave modport)
//   err        : any check failed (sticky)
//   err_code   : code of the first failure, 0 = none
//   err_order  : rvfi_order of the failing beat (next expected order on timeout)
//   retired    : error-free beats accepted while running
//   halted     : a clean halt beat has been seen
module rvfi_monitor
    import riscv_rvfi_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TIMEOUT    = 1024,
    parameter bit CHECK_REGS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    rvfi_monitor_if.slave       rvfi,
    output logic                err,
    output logic [3:0]          err_code,
    output logic [63:0]         err_order,
    output logic [63:0]         retired,
    output logic                halted
);
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    mon_state_e      state_q, state_d;
    logic [63:0]     exp_order_q;
    logic [XLEN-1:0] last_pc_q;
    logic            pc_armed_q;
    logic [TMO_W-1:0] tmo_cnt_q;

    err_code_e       beat_code_p0, cycle_code_p0;
    logic            beat_ok_p0, tmo_hit_p0, mask_bad_p0, rs1_bad_p0, rs2_bad_p0;
    logic [XLEN-1:0] rs1_sh_data, rs2_sh_data;
    logic            rs1_sh_vld, rs2_sh_vld;
    logic            unused_bits;

    assign unused_bits = ^{rvfi.rvfi_insn, rvfi.rvfi_intr, rvfi.rvfi_mem_addr[XLEN-1:2]};

    rvfi_shadow_regfile #(.XLEN(XLEN)) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .we       (beat_ok_p0 && !rvfi.rvfi_trap),
        .waddr    (rvfi.rvfi_rd_addr),
        .wdata    (rvfi.rvfi_rd_wdata),
        .raddr_a  (rvfi.rvfi_rs1_addr),
        .rdata_a  (rs1_sh_data),
        .rvalid_a (rs1_sh_vld),
        .raddr_b  (rvfi.rvfi_rs2_addr),
        .rdata_b  (rs2_sh_data),
        .rvalid_b (rs2_sh_vld)
    );

    // ---- stage p0: classify the current beat ----
    // The shadow is read before this beat's write lands, so rs compares see
    // the pre-update value even when rd == rs.
    always_comb begin
        mask_bad_p0 = !mask_legal(rvfi.rvfi_mem_rmask, rvfi.rvfi_mem_addr[1:0]) ||
                      !mask_legal(rvfi.rvfi_mem_wmask, rvfi.rvfi_mem_addr[1:0]);
        rs1_bad_p0  = CHECK_REGS && rs1_sh_vld && (rvfi.rvfi_rs1_rdata != rs1_sh_data);
        rs2_bad_p0  = CHECK_REGS && rs2_sh_vld && (rvfi.rvfi_rs2_rdata != rs2_sh_data);
        tmo_hit_p0  = (TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

        beat_code_p0 = ERR_NONE;
        if (rvfi.rvfi_order != exp_order_q) begin
            beat_code_p0 = ERR_ORDER;
        end else if (pc_armed_q && rvfi.rvfi_pc_rdata != last_pc_q) begin
            beat_code_p0 = ERR_PC;
        end else if (!rvfi.rvfi_trap) begin
            if (rvfi.rvfi_rd_addr == 5'd0 && rvfi.rvfi_rd_wdata != '0) begin
                beat_code_p0 = ERR_X0;
            end else if (rs1_bad_p0) begin
                beat_code_p0 = ERR_RS1;
            end else if (rs2_bad_p0) begin
                beat_code_p0 = ERR_RS2;
            end else if (mask_bad_p0) begin
                beat_code_p0 = ERR_MASK;
            end
        end
    end

    // FSM output logic: what this cycle reports, and whether the beat is accepted.
    always_comb begin
        cycle_code_p0 = ERR_NONE;
        beat_ok_p0    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (rvfi.rvfi_valid) begin
                    cycle_code_p0 = beat_code_p0;
                    beat_ok_p0    = (beat_code_p0 == ERR_NONE);
                end else if (tmo_hit_p0) begin
                    cycle_code_p0 = ERR_TIMEOUT;
                end
            end
            ST_HALTED: begin
                if (rvfi.rvfi_valid) begin
                    cycle_code_p0 = ERR_HALT;
                end
            end
            default: ;
        endcase
    end

    // FSM next-state logic; FAIL holds until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (cycle_code_p0 != ERR_NONE) begin
                    state_d = ST_FAIL;
                end else if (beat_ok_p0 && rvfi.rvfi_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (cycle_code_p0 != ERR_NONE) begin
                    state_d = ST_FAIL;
                end
            end
            default: ;
        endcase
    end

    // ---- stage p1: registered state and reports ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            exp_order_q <= '0;
            pc_armed_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            err         <= 1'b0;
            err_code    <= 4'd0;
            err_order   <= '0;
            retired     <= '0;
            halted      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cycle_code_p0 != ERR_NONE) begin
                err       <= 1'b1;
                err_code  <= cycle_code_p0;
                err_order <= rvfi.rvfi_valid ? rvfi.rvfi_order : exp_order_q;
            end
            if (beat_ok_p0) begin
                exp_order_q <= rvfi.rvfi_order + 64'd1;
                pc_armed_q  <= 1'b1;
                retired     <= retired + 64'd1;
                if (rvfi.rvfi_halt) begin
                    halted <= 1'b1;
                end
            end
            // Liveness only counts while running; saturates at TIMEOUT.
            if (state_q == ST_RUN) begin
                if (rvfi.rvfi_valid) begin
                    tmo_cnt_q <= '0;
                end else if (tmo_cnt_q != TMO_W'(TIMEOUT)) begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
            end
        end
    end

    // PC of the last accepted beat; only meaningful once the chain is armed.
    always_ff @(posedge clk) begin
        if (beat_ok_p0) begin
            last_pc_q <= rvfi.rvfi_pc_wdata;
        end
    end
endmodule

// File: tb/tb_rvfi_monitor.sv
module tb_rvfi_monitor;
    localparam int XLEN = 32;
    localparam int TMO  = 8;

    typedef struct {
        logic [63:0] order;
        logic        trap;
        logic        halt;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1_rdata, rs2_rdata, rd_wdata;
        logic [31:0] pc_rdata, pc_wdata, mem_addr;
        logic [3:0]  rmask, wmask;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        err;
    logic [3:0]  err_code;
    logic [63:0] err_order;
    logic [63:0] retired;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rvfi_monitor_if #(.XLEN(XLEN)) rvfi_bus ();

    rvfi_monitor #(.XLEN(XLEN), .TIMEOUT(TMO), .CHECK_REGS(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rvfi      (rvfi_bus),
        .err       (err),
        .err_code  (err_code),
        .err_order (err_order),
        .retired   (retired),
        .halted    (halted)
    );

    // ---------------- reference model ----------------
    bit          m_failed;
    bit          m_halted;
    logic        m_err;
    logic [3:0]  m_code;
    logic [63:0] m_eorder;
    logic [63:0] m_retired;
    logic [63:0] m_exp;
    logic [31:0] m_last_pc;
    bit          m_armed;
    logic [31:0] m_shadow [32];
    bit          m_sv [32];
    int          m_idle;

    logic [3:0]  legal_masks [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    task automatic model_reset();
        m_failed = 0; m_halted = 0; m_err = 0; m_code = 0; m_eorder = 0;
        m_retired = 0; m_exp = 0; m_last_pc = 0; m_armed = 0; m_idle = 0;
        for (int i = 0; i < 32; i++) begin
            m_sv[i] = 0;
            m_shadow[i] = 0;
        end
    endtask

    function automatic bit tb_mask_ok(input logic [3:0] m, input logic [31:0] a);
        if (!(m inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF})) return 0;
        if ($countones(m) == 2 && (a % 2) != 0) return 0;
        if ($countones(m) == 4 && (a % 4) != 0) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit v, input beat_t x);
        int code;
        code = 0;
        if (m_failed) return;
        if (v && m_halted) begin
            code = 7;
        end else if (v) begin
            // Evaluate from lowest priority up so the most important wins.
            if (!x.trap) begin
                if (!tb_mask_ok(x.rmask, x.mem_addr) || !tb_mask_ok(x.wmask, x.mem_addr)) code = 6;
                if (x.rs2 != 0 && m_sv[x.rs2] && x.rs2_rdata != m_shadow[x.rs2]) code = 5;
                if (x.rs1 != 0 && m_sv[x.rs1] && x.rs1_rdata != m_shadow[x.rs1]) code = 4;
                if (x.rd == 0 && x.rd_wdata != 0) code = 3;
            end
            if (m_armed && x.pc_rdata != m_last_pc) code = 2;
            if (x.order != m_exp) code = 1;
        end else if (!m_halted) begin
            m_idle++;
            if (m_idle >= TMO) code = 8;
        end

        if (code != 0) begin
            m_failed = 1;
            m_err    = 1;
            m_code   = code[3:0];
            m_eorder = v ? x.order : m_exp;
        end else if (v) begin
            m_retired++;
            m_exp     = x.order + 1;
            m_last_pc = x.pc_rdata == x.pc_rdata ? x.pc_wdata : x.pc_wdata;
            m_armed   = 1;
            m_idle    = 0;
            if (!x.trap && x.rd != 0) begin
                m_shadow[x.rd] = x.rd_wdata;
                m_sv[x.rd]     = 1;
            end
            if (x.halt) m_halted = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("err",       64'(err),       64'(m_err));
        check("err_code",  64'(err_code),  64'(m_code));
        check("err_order", err_order,      m_eorder);
        check("retired",   retired,        m_retired);
        check("halted",    64'(halted),    64'(m_halted));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input beat_t x);
        rvfi_bus.rvfi_valid     = v;
        rvfi_bus.rvfi_order     = x.order;
        rvfi_bus.rvfi_insn      = $urandom;
        rvfi_bus.rvfi_trap      = x.trap;
        rvfi_bus.rvfi_halt      = x.halt;
        rvfi_bus.rvfi_intr      = 1'b0;
        rvfi_bus.rvfi_rs1_addr  = x.rs1;
        rvfi_bus.rvfi_rs2_addr  = x.rs2;
        rvfi_bus.rvfi_rd_addr   = x.rd;
        rvfi_bus.rvfi_rs1_rdata = x.rs1_rdata;
        rvfi_bus.rvfi_rs2_rdata = x.rs2_rdata;
        rvfi_bus.rvfi_rd_wdata  = x.rd_wdata;
        rvfi_bus.rvfi_pc_rdata  = x.pc_rdata;
        rvfi_bus.rvfi_pc_wdata  = x.pc_wdata;
        rvfi_bus.rvfi_mem_addr  = x.mem_addr;
        rvfi_bus.rvfi_mem_rmask = x.rmask;
        rvfi_bus.rvfi_mem_wmask = x.wmask;
    endtask

    function automatic beat_t base_beat(input logic [63:0] ord, input logic [31:0] pc);
        beat_t x;
        x.order = ord; x.trap = 0; x.halt = 0;
        x.rs1 = 0; x.rs2 = 0; x.rd = 0;
        x.rs1_rdata = 0; x.rs2_rdata = 0; x.rd_wdata = 0;
        x.pc_rdata = pc; x.pc_wdata = pc + 4; x.mem_addr = 0;
        x.rmask = 0; x.wmask = 0;
        return x;
    endfunction

    task automatic step(input bit v, input beat_t x);
        drive(v, x);
        model_step(v, x);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        beat_t x;
        x = base_beat(0, 0);
        for (int i = 0; i < n; i++) step(0, x);
    endtask

    task automatic do_reset();
        beat_t x;
        x = base_beat(0, 0);
        drive(0, x);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_err",       64'(err),      64'd0);
        check("rst_err_code",  64'(err_code), 64'd0);
        check("rst_err_order", err_order,     64'd0);
        check("rst_retired",   retired,       64'd0);
        check("rst_halted",    64'(halted),   64'd0);
    endtask

    task automatic make_beat(output beat_t x);
        logic [3:0] rm, wm;
        x = base_beat(m_exp, m_armed ? m_last_pc : ($urandom & 32'hFFFF_FFFC));
        if ($urandom_range(0, 4) == 0) x.pc_wdata = $urandom & 32'hFFFF_FFFC;
        x.rd       = 5'($urandom_range(0, 31));
        x.rd_wdata = (x.rd == 0) ? 32'd0 : $urandom;
        x.rs1      = 5'($urandom_range(0, 31));
        x.rs1_rdata = m_sv[x.rs1] ? m_shadow[x.rs1] : $urandom;
        x.rs2      = 5'($urandom_range(0, 31));
        x.rs2_rdata = m_sv[x.rs2] ? m_shadow[x.rs2] : $urandom;
        rm = legal_masks[$urandom_range(0, 7)];
        wm = legal_masks[$urandom_range(0, 7)];
        x.rmask = rm;
        x.wmask = wm;
        x.mem_addr = $urandom;
        if ($countones(rm) == 4 || $countones(wm) == 4) x.mem_addr = x.mem_addr & 32'hFFFF_FFFC;
        else if ($countones(rm) == 2 || $countones(wm) == 2) x.mem_addr = x.mem_addr & 32'hFFFF_FFFE;
        x.trap = ($urandom_range(0, 9) == 0);
        x.halt = ($urandom_range(0, 49) == 0);
        // Independent, rare faults; several may coincide to exercise priority.
        if ($urandom_range(0, 33) == 0) x.order = x.order + 64'($urandom_range(1, 4));
        if ($urandom_range(0, 33) == 0) x.pc_rdata = x.pc_rdata ^ 32'h4;
        if ($urandom_range(0, 33) == 0) begin x.rd = 0; x.rd_wdata = $urandom | 32'h1; end
        if ($urandom_range(0, 33) == 0) x.rs1_rdata = x.rs1_rdata ^ 32'h1;
        if ($urandom_range(0, 33) == 0) x.rs2_rdata = x.rs2_rdata ^ 32'h1;
        if ($urandom_range(0, 33) == 0) begin
            if ($urandom_range(0, 1) == 0) x.rmask = 4'b0101;
            else begin x.wmask = 4'b1111; x.mem_addr = x.mem_addr | 32'h2; end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        beat_t b;
        int    stuck;
        int    r;

        rst = 1'b1;
        b = base_beat(0, 0);
        drive(0, b);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Clean run with pc chain 0 -> 4 -> 8 and x5 written.
        for (int i = 0; i < 3; i++) begin
            b = base_beat(64'(i), 32'(4 * i));
            b.rd = 5'd5;
            b.rd_wdata = 32'd7;
            step(1, b);
        end
        check("t1_err",     64'(err), 64'd0);
        check("t1_retired", retired,  64'd3);

        // Order skip.
        do_reset();
        step(1, base_beat(0, 0));
        step(1, base_beat(2, 4));
        check("t2_err",       64'(err),      64'd1);
        check("t2_err_code",  64'(err_code), 64'd1);
        check("t2_err_order", err_order,     64'd2);

        // Register coherence: wrong then right value.
        do_reset();
        b = base_beat(0, 0); b.rd = 5'd5; b.rd_wdata = 32'h11;
        step(1, b);
        b = base_beat(1, 4); b.rs1 = 5'd5; b.rs1_rdata = 32'h12;
        step(1, b);
        check("t3_rs1_bad", 64'(err_code), 64'd4);
        do_reset();
        b = base_beat(0, 0); b.rd = 5'd5; b.rd_wdata = 32'h11;
        step(1, b);
        b = base_beat(1, 4); b.rs1 = 5'd5; b.rs1_rdata = 32'h11;
        step(1, b);
        check("t3_rs1_ok", 64'(err), 64'd0);

        // Same-beat read-after-write uses the old shadow value.
        b = base_beat(2, 8); b.rd = 5'd5; b.rd_wdata = 32'h99; b.rs1 = 5'd5; b.rs1_rdata = 32'h11;
        step(1, b);
        check("t3_raw", 64'(err), 64'd0);

        // x0 write with and without a simultaneous order fault.
        do_reset();
        step(1, base_beat(0, 0));
        b = base_beat(5, 4); b.rd = 5'd0; b.rd_wdata = 32'd1;
        step(1, b);
        check("t4_prio", 64'(err_code), 64'd1);
        do_reset();
        b = base_beat(0, 0); b.rd = 5'd0; b.rd_wdata = 32'd1;
        step(1, b);
        check("t4_x0", 64'(err_code), 64'd3);

        // Beat after halt.
        do_reset();
        b = base_beat(0, 0); b.halt = 1'b1;
        step(1, b);
        check("t5_halted",   64'(halted), 64'd1);
        check("t5_halt_err", 64'(err),    64'd0);
        step(1, base_beat(1, 4));
        check("t5_halt_code",   64'(err_code), 64'd7);
        check("t5_halted_stay", 64'(halted),   64'd1);

        // Liveness: TMO-1 idle cycles are fine, the TMO-th is not.
        do_reset();
        idle(TMO - 1);
        check("t5_tmo_early", 64'(err), 64'd0);
        idle(1);
        check("t5_tmo_code", 64'(err_code), 64'd8);
        idle(3);
        check("t5_fail_hold", 64'(err_code), 64'd8);

        // Reset out of FAIL, then a clean start.
        do_reset();
        step(1, base_beat(0, 0));
        check("t6_err",     64'(err), 64'd0);
        check("t6_retired", retired,  64'd1);

        // Randomized traffic against the model.
        do_reset();
        stuck = 0;
        for (int i = 0; i < 2000; i++) begin
            if (m_failed || m_halted) begin
                stuck++;
                if (stuck > 2) begin
                    do_reset();
                    stuck = 0;
                    continue;
                end
            end
            r = $urandom_range(0, 99);
            if (r < 1) begin
                idle(TMO + 1);
            end else if (r < 30) begin
                idle(1);
            end else begin
                make_beat(b);
                step(1, b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
